// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// The fetch stage is the master: it issues req/addr and consumes ready/rdata.
interface fetch_stage_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, variable-latency imem handshake and IF/ID register.
// Accepts stall/flush from ID; a one-entry skid captures data that lands during a stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [31:0]        redirect_target_i,
  fetch_stage_if.master      imem,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc_plus4,
  output logic [31:0]        if_id_instr,
  output logic               if_id_valid,
  output logic               fetch_busy
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [XLEN-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;
  logic            if_id_valid_q, if_id_valid_d;
  logic            fetch_busy_q, fetch_busy_d;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;

  assign target   = redirect_target_i & ~XLEN'(3);
  assign pc_plus4 = pc_q + XLEN'(4);

  // Request depends only on state so imem never sees req react to its own ready.
  assign imem.imem_req  = reset_n && (state_q != HOLD);
  assign imem.imem_addr = pc_q;

  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_valid    = if_id_valid_q;
  assign fetch_busy     = fetch_busy_q;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    skid_pc_d        = skid_pc_q;
    skid_instr_d     = skid_instr_q;
    redir_d          = redir_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_valid_d    = if_id_valid_q;

    unique case (state_q)
      FETCH: begin
        if (imem.imem_ready) begin
          if (flush_i) begin
            pc_d          = target;
            if_id_valid_d = 1'b0;
            if_id_instr_d = '0;
          end else if (stall_i) begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem.imem_rdata;
            pc_d         = pc_plus4;
            state_d      = HOLD;
          end else begin
            if_id_pc_d       = pc_q;
            if_id_pc_plus4_d = pc_plus4;
            if_id_instr_d    = imem.imem_rdata;
            if_id_valid_d    = 1'b1;
            pc_d             = pc_plus4;
          end
        end else if (flush_i) begin
          redir_d       = target;
          if_id_valid_d = 1'b0;
          if_id_instr_d = '0;
          state_d       = DISCARD;
        end else if (!stall_i) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = '0;
        end
      end

      HOLD: begin
        if (flush_i) begin
          pc_d          = target;
          if_id_valid_d = 1'b0;
          if_id_instr_d = '0;
          state_d       = FETCH;
        end else if (!stall_i) begin
          if_id_pc_d       = skid_pc_q;
          if_id_pc_plus4_d = skid_pc_q + XLEN'(4);
          if_id_instr_d    = skid_instr_q;
          if_id_valid_d    = 1'b1;
          state_d          = FETCH;
        end
      end

      DISCARD: begin
        // Wait out the stale request; its data is never used.
        if (flush_i) begin
          redir_d       = target;
          if_id_valid_d = 1'b0;
          if_id_instr_d = '0;
        end else if (!stall_i) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = '0;
        end
        if (imem.imem_ready) begin
          pc_d    = flush_i ? target : redir_q;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase

    fetch_busy_d = (state_d != FETCH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= FETCH;
      pc_q             <= RESET_PC;
      skid_pc_q        <= '0;
      skid_instr_q     <= '0;
      redir_q          <= '0;
      if_id_pc_q       <= '0;
      if_id_pc_plus4_q <= '0;
      if_id_instr_q    <= '0;
      if_id_valid_q    <= 1'b0;
      fetch_busy_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      skid_pc_q        <= skid_pc_d;
      skid_instr_q     <= skid_instr_d;
      redir_q          <= redir_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_valid_q    <= if_id_valid_d;
      fetch_busy_q     <= fetch_busy_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/flush/latency traffic,
// compared against a transaction-level model of the fetch pipeline.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] redirect_target_i;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fetch_busy;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .stall_i           (stall_i),
    .flush_i           (flush_i),
    .redirect_target_i (redirect_target_i),
    .imem              (imem_bus),
    .if_id_pc          (if_id_pc),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_instr       (if_id_instr),
    .if_id_valid       (if_id_valid),
    .fetch_busy        (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: next fetch address, pending redirect, and a queue for a stalled-off instruction.
  logic [31:0] m_pc;
  logic [31:0] m_redir;
  logic        m_discard;
  logic [63:0] m_skid[$];
  logic [31:0] e_pc, e_pc4, e_instr;
  logic        e_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_redir = '0; m_discard = 1'b0; m_skid.delete();
    e_pc = '0; e_pc4 = '0; e_instr = '0; e_valid = 1'b0;
  endtask

  task automatic bubble();
    e_valid = 1'b0; e_instr = '0;
  endtask

  task automatic load(input logic [31:0] p, input logic [31:0] i);
    e_pc = p; e_pc4 = p + 32'd4; e_instr = i; e_valid = 1'b1;
  endtask

  task automatic check_mem_side();
    chk("imem_req", {31'b0, imem_bus.imem_req}, {31'b0, reset_n && (m_skid.size() == 0)});
    chk("imem_addr", imem_bus.imem_addr, m_pc);
  endtask

  task automatic check_ifid();
    chk("if_id_pc", if_id_pc, e_pc);
    chk("if_id_pc_plus4", if_id_pc_plus4, e_pc4);
    chk("if_id_instr", if_id_instr, e_instr);
    chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e_valid});
    chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, (m_skid.size() != 0) || m_discard});
  endtask

  // One clock: apply inputs, check request side, advance model, check IF/ID after the edge.
  task automatic cycle(input logic s, input logic f, input logic [31:0] t, input logic r);
    logic [31:0] tgt;
    logic [63:0] sk;
    @(negedge clk);
    reset_n = 1'b1;
    stall_i = s; flush_i = f; redirect_target_i = t;
    imem_bus.imem_ready = r;
    imem_bus.imem_rdata = mem_word(m_pc);
    #1;
    check_mem_side();
    tgt = {t[31:2], 2'b00};
    if (m_skid.size() != 0) begin
      if (f) begin
        m_skid.delete(); m_pc = tgt; bubble();
      end else if (!s) begin
        sk = m_skid.pop_front();
        load(sk[63:32], sk[31:0]);
      end
    end else if (m_discard) begin
      if (f) begin
        m_redir = tgt; bubble();
      end else if (!s) begin
        bubble();
      end
      if (r) begin
        m_pc = m_redir; m_discard = 1'b0;
      end
    end else if (r) begin
      if (f) begin
        m_pc = tgt; bubble();
      end else if (s) begin
        m_skid.push_back({m_pc, mem_word(m_pc)}); m_pc = m_pc + 32'd4;
      end else begin
        load(m_pc, mem_word(m_pc)); m_pc = m_pc + 32'd4;
      end
    end else if (f) begin
      m_discard = 1'b1; m_redir = tgt; bubble();
    end else if (!s) begin
      bubble();
    end
    @(posedge clk);
    #1;
    check_ifid();
  endtask

  // Drop reset between clock edges and expect reset values with no edge in between.
  task automatic reset_mid();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    imem_bus.imem_ready = 1'b0;
    #1;
    model_reset();
    check_mem_side();
    check_ifid();
    @(posedge clk);
    #1;
    check_ifid();
  endtask

  initial begin
    reset_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; redirect_target_i = '0;
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = '0;
    model_reset();
    #1;
    check_mem_side();
    check_ifid();
    @(posedge clk);
    #1;
    check_ifid();

    // Zero-wait streaming
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    chk("stream_pc_last", if_id_pc, 32'd12);

    // Two wait states per fetch
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b0);
      cycle(1'b0, 1'b0, '0, 1'b1);
    end

    // Stall while data returns, then release
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Flush while a request is pending
    cycle(1'b0, 1'b1, 32'h100, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("redirect_addr", imem_bus.imem_addr, 32'h100);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("redirect_first_pc", if_id_pc, 32'h100);

    // Stall and flush together: flush wins
    cycle(1'b1, 1'b1, 32'h40, 1'b1);
    chk("flush_wins_addr", imem_bus.imem_addr, 32'h40);
    chk("flush_wins_bubble", {31'b0, if_id_valid}, 32'd0);

    // Misaligned target and PC wraparound
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("wrap_addr", imem_bus.imem_addr, 32'h0);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Reset mid-HOLD and mid-DISCARD
    cycle(1'b1, 1'b0, '0, 1'b1);
    reset_mid();
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b1, 32'h200, 1'b0);
    reset_mid();
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
            $urandom(), ($urandom_range(0, 9) < 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
